a_rf_loader: RTL and testbench
==============================

A_RF_LOADER -- requirements
Module: a_rf_loader

Interface
REQ-001 Parameter registerfile_size, default 8: depth of the target A register file.
REQ-002 Parameter registerfile_size_log, default $clog2(registerfile_size): address width (L).
REQ-003 The block SHALL use one clock, clk, and a synchronous, active-high reset, RST; RST is sampled only on the rising edge of clk.
REQ-004 The ports SHALL be as listed, clock and reset first:
- clk  in  1  clock
- RST  in  1  synchronous active-high reset
- start  in  1  begin a load/read job (sampled in IDLE only)
- abort  in  1  cancel the current job
- burst_len  in  L+1  words to load, legal range 1..registerfile_size
- repeat_cnt  in  4  extra read sweeps after the first
- s_data  in  30  input word
- s_valid  in  1  input word valid
- s_ready  out  1  block accepts s_data
- A  out  30  data to the register file
- RF_load  out  1  one-cycle shift strobe to the register file
- ACOUT_addr  out  L  read-out address to the register file
- rd_valid  out  1  ACOUT_addr is presenting a valid word
- rd_ready  in  1  downstream accepts the current word
- busy  out  1  block is not in IDLE
- done  out  1  one-cycle job-complete pulse

Function
REQ-005 The FSM SHALL have exactly five states: IDLE, LOAD, FLUSH, READ, DONE.
REQ-006 In IDLE with start=1, the block SHALL latch N = min(burst_len, registerfile_size) and R = repeat_cnt, then go to LOAD.
REQ-007 In IDLE with start=1 and burst_len=0, the block SHALL go directly to DONE; no RF_load is issued.
REQ-008 s_ready SHALL be 1 only in LOAD (combinational from state).
REQ-009 Each handshake (s_valid & s_ready) SHALL register A<=s_data and RF_load<=1 for the next cycle only.
REQ-010 RF_load SHALL be 0 in every cycle not preceded by a handshake; A SHALL hold its last value.
REQ-011 The load counter SHALL count handshakes; the handshake that makes the count equal N SHALL move the FSM to FLUSH.
REQ-012 FLUSH SHALL last exactly one cycle, during which the final RF_load is visible; the FSM then goes to READ.
REQ-013 On FLUSH exit, ACOUT_addr SHALL be N (word index k=0), the pass counter 0, and k 0.
REQ-014 After N loads, word k (0-based arrival order) resides at register-file entry N-1-k. ACOUT_addr=N-k therefore selects word k, because ACOUT reads entry ACOUT_addr-1.
REQ-015 rd_valid SHALL be 1 exactly in READ; ACOUT_addr SHALL change only on rd_valid & rd_ready.
REQ-016 On a read handshake with k<N-1: k<=k+1 and ACOUT_addr<=N-k-1.
REQ-017 On a read handshake with k=N-1 and pass<R: k<=0, pass<=pass+1, ACOUT_addr<=N.
REQ-018 On a read handshake with k=N-1 and pass=R: the FSM goes to DONE.
REQ-019 ACOUT_addr SHALL never be 0 while rd_valid=1, so the input-bypass path is never selected.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE; done SHALL be 0 in all other cycles.
REQ-021 busy SHALL be 1 in LOAD, FLUSH, READ and DONE.
REQ-022 abort=1 in any state other than IDLE SHALL force IDLE on the next edge, with RF_load=0, rd_valid=0 and done=0.
REQ-023 abort has priority over every handshake in the same cycle; the aborted word is not loaded.
REQ-024 start outside IDLE SHALL be ignored; burst_len and repeat_cnt changes after latching SHALL be ignored.

Reset
REQ-025 RST=1 SHALL, on the next edge, set state=IDLE, A=0, RF_load=0, ACOUT_addr=0, and clear all counters.
REQ-026 While in reset: s_ready=0, rd_valid=0, busy=0, done=0.
REQ-027 RST SHALL override abort and start in the same cycle.
REQ-028 Reset mid-job SHALL discard the job without further RF_load pulses.

Verification
REQ-029 Nominal job: burst_len=4, repeat_cnt=0, words 0x11,0x22,0x33,0x44 with s_valid held high -> four consecutive RF_load pulses; one FLUSH cycle; ACOUT_addr sequence 4,3,2,1 with rd_ready=1; done pulses one cycle after the last read.
REQ-030 Backpressure: s_valid toggling 1,0,1,0... and rd_ready low for 3 cycles on k=2 -> RF_load only after accepted words; ACOUT_addr held at 2 for 3 cycles; no word skipped.
REQ-031 Repeat and clamp: burst_len=12 with size 8, repeat_cnt=2 -> exactly 8 loads, then ACOUT_addr 8..1 issued three times (24 read handshakes), then done.
REQ-032 Zero length: burst_len=0 with start -> done asserted 1 cycle later; s_ready, RF_load and rd_valid never asserted.
REQ-033 Abort/reset: abort in the same cycle as the 3rd load handshake -> no 3rd RF_load and IDLE next cycle; RST during READ -> all outputs at reset values next cycle; a new start then runs normally.
REQ-034 Start while busy: start pulsed during READ with burst_len=2 -> current job unaffected; the new request is not latched.

Source files
------------

// File: rtl/a_rf_loader_if.sv
// Handshake and register-file bus between the A loader and its neighbours.
// Addresses run 1..registerfile_size, so counts and addresses carry L+1 bits.
interface a_rf_loader_if #(
  parameter int unsigned registerfile_size     = 8,
  parameter int unsigned registerfile_size_log = $clog2(registerfile_size)
);
  localparam int unsigned AW = registerfile_size_log + 1;

  logic          start;
  logic          abort;
  logic [AW-1:0] burst_len;
  logic [3:0]    repeat_cnt;
  logic [29:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic [29:0]   A;
  logic          RF_load;
  logic [AW-1:0] ACOUT_addr;
  logic          rd_valid;
  logic          rd_ready;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, burst_len, repeat_cnt, s_data, s_valid, rd_ready,
    input  s_ready, A, RF_load, ACOUT_addr, rd_valid, busy, done
  );

  modport slave (
    input  start, abort, burst_len, repeat_cnt, s_data, s_valid, rd_ready,
    output s_ready, A, RF_load, ACOUT_addr, rd_valid, busy, done
  );
endinterface

// File: rtl/a_rf_loader.sv
// Streams N words into a shift-style A register file, then sweeps them back
// out in arrival order R+1 times through ACOUT_addr.
module a_rf_loader #(
  parameter int unsigned registerfile_size     = 8,
  parameter int unsigned registerfile_size_log = $clog2(registerfile_size)
) (
  input logic         clk,
  input logic         RST,
  a_rf_loader_if.slave ld_if
);

  localparam int unsigned CW = registerfile_size_log + 1;
  localparam int unsigned DW = 30;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] n_q, n_d;
  logic [3:0]    r_q, r_d;
  logic [CW-1:0] load_cnt_q, load_cnt_d;
  logic [CW-1:0] k_q, k_d;
  logic [3:0]    pass_q, pass_d;
  logic [CW-1:0] addr_q, addr_d;
  logic [DW-1:0] a_q, a_d;
  logic          rf_load_q, rf_load_d;

  logic          s_ready_c, rd_valid_c, busy_c, done_c;
  logic          s_hs, rd_hs;
  logic          last_load, last_word, last_pass;
  logic [CW-1:0] n_clamp;

  // Abort wins over both handshakes, so an aborted word never reaches the file.
  assign s_hs      = s_ready_c  && ld_if.s_valid  && !ld_if.abort;
  assign rd_hs     = rd_valid_c && ld_if.rd_ready && !ld_if.abort;
  assign last_load = (load_cnt_q + CW'(1)) == n_q;
  assign last_word = k_q == (n_q - CW'(1));
  assign last_pass = pass_q == r_q;
  assign n_clamp   = (ld_if.burst_len > CW'(registerfile_size)) ?
                     CW'(registerfile_size) : ld_if.burst_len;

  // State register.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ld_if.start) begin
          state_d = (ld_if.burst_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (ld_if.abort) begin
          state_d = IDLE;
        end else if (s_hs && last_load) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = ld_if.abort ? IDLE : READ;
      end
      READ: begin
        if (ld_if.abort) begin
          state_d = IDLE;
        end else if (rd_hs && last_word && last_pass) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decode the state; all of them drop while RST is high.
  always_comb begin
    s_ready_c  = 1'b0;
    rd_valid_c = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    if (!RST) begin
      case (state_q)
        LOAD: begin
          s_ready_c = 1'b1;
          busy_c    = 1'b1;
        end
        FLUSH: begin
          busy_c = 1'b1;
        end
        READ: begin
          rd_valid_c = 1'b1;
          busy_c     = 1'b1;
        end
        DONE: begin
          done_c = 1'b1;
          busy_c = 1'b1;
        end
        default: begin
          busy_c = 1'b0;
        end
      endcase
    end
  end

  // Datapath next values: job latch, load count, read sweep position.
  always_comb begin
    n_d        = n_q;
    r_d        = r_q;
    load_cnt_d = load_cnt_q;
    k_d        = k_q;
    pass_d     = pass_q;
    addr_d     = addr_q;
    a_d        = a_q;
    rf_load_d  = s_hs;
    if (s_hs) begin
      a_d = ld_if.s_data;
    end
    case (state_q)
      IDLE: begin
        if (ld_if.start) begin
          n_d        = n_clamp;
          r_d        = ld_if.repeat_cnt;
          load_cnt_d = '0;
        end
      end
      LOAD: begin
        if (s_hs) begin
          load_cnt_d = load_cnt_q + CW'(1);
        end
      end
      FLUSH: begin
        // Word 0 sits in entry N-1, read through address N.
        if (!ld_if.abort) begin
          addr_d = n_q;
          k_d    = '0;
          pass_d = '0;
        end
      end
      READ: begin
        if (rd_hs) begin
          if (!last_word) begin
            k_d    = k_q + CW'(1);
            addr_d = n_q - k_q - CW'(1);
          end else if (!last_pass) begin
            k_d    = '0;
            pass_d = pass_q + 4'd1;
            addr_d = n_q;
          end
        end
      end
      default: begin
        k_d = k_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      n_q        <= '0;
      r_q        <= '0;
      load_cnt_q <= '0;
      k_q        <= '0;
      pass_q     <= '0;
      addr_q     <= '0;
      a_q        <= '0;
      rf_load_q  <= 1'b0;
    end else begin
      n_q        <= n_d;
      r_q        <= r_d;
      load_cnt_q <= load_cnt_d;
      k_q        <= k_d;
      pass_q     <= pass_d;
      addr_q     <= addr_d;
      a_q        <= a_d;
      rf_load_q  <= rf_load_d;
    end
  end

  assign ld_if.s_ready    = s_ready_c;
  assign ld_if.rd_valid   = rd_valid_c;
  assign ld_if.busy       = busy_c;
  assign ld_if.done       = done_c;
  assign ld_if.A          = a_q;
  assign ld_if.RF_load    = rf_load_q;
  assign ld_if.ACOUT_addr = addr_q;

endmodule

// File: tb/tb_a_rf_loader.sv
// Randomized jobs against a transaction model of the loader plus a shift-style
// register file; read-back data is checked against arrival order.
module tb_a_rf_loader;
  localparam int unsigned SIZE = 8;
  localparam int unsigned L    = $clog2(SIZE);
  localparam int unsigned CW   = L + 1;

  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  a_rf_loader_if #(.registerfile_size(SIZE)) ifc ();

  a_rf_loader #(.registerfile_size(SIZE)) dut (
    .clk   (clk),
    .RST   (RST),
    .ld_if (ifc.slave)
  );

  int vectors = 0;
  int errors  = 0;
  logic [29:0] rf [SIZE];
  logic [29:0] words [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; the modelled register file shifts on each RF_load.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ifc.RF_load === 1'b1) begin
      for (int i = SIZE - 1; i > 0; i--) rf[i] = rf[i-1];
      rf[0] = ifc.A;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_A"},       32'(ifc.A), 32'd0);
    check_eq({tag, "_rfload"},  32'(ifc.RF_load), 32'd0);
    check_eq({tag, "_addr"},    32'(ifc.ACOUT_addr), 32'd0);
    check_eq({tag, "_sready"},  32'(ifc.s_ready), 32'd0);
    check_eq({tag, "_rdvalid"}, 32'(ifc.rd_valid), 32'd0);
    check_eq({tag, "_busy"},    32'(ifc.busy), 32'd0);
    check_eq({tag, "_done"},    32'(ifc.done), 32'd0);
  endtask

  // One job: phase 0 load, 1 flush, 2 read, 3 done, 4 back in idle.
  task automatic run_job(input int n_req, input int r, input int pv, input int pr,
                         input int abort_at, input int rst_at, input bit fixed_data,
                         input bit hold_k2, input bit noise);
    int n, loaded, phase, nxt, reads, cycles, hold, a0;
    bit prev_hs;
    logic [29:0] prev_w, w;
    int addrq [$];
    words.delete();
    n = (n_req > int'(SIZE)) ? int'(SIZE) : n_req;
    ifc.burst_len  = CW'(n_req);
    ifc.repeat_cnt = 4'(r);
    ifc.start      = 1'b1;
    tick();
    ifc.start = 1'b0;
    if (noise) begin
      ifc.burst_len  = CW'($urandom);
      ifc.repeat_cnt = 4'($urandom);
    end
    if (n == 0) begin
      check_eq("zero_done",    32'(ifc.done), 32'd1);
      check_eq("zero_busy",    32'(ifc.busy), 32'd1);
      check_eq("zero_sready",  32'(ifc.s_ready), 32'd0);
      check_eq("zero_rdvalid", 32'(ifc.rd_valid), 32'd0);
      check_eq("zero_rfload",  32'(ifc.RF_load), 32'd0);
      tick();
      check_eq("zero_done_clr", 32'(ifc.done), 32'd0);
      check_eq("zero_idle",     32'(ifc.busy), 32'd0);
      check_eq("zero_rfload2",  32'(ifc.RF_load), 32'd0);
      return;
    end
    for (int p = 0; p <= r; p++)
      for (int k = 0; k < n; k++) addrq.push_back(n - k);
    phase = 0; loaded = 0; prev_hs = 0; prev_w = '0; reads = 0; cycles = 0; hold = 0;
    while (phase != 4 && cycles < 2000) begin
      cycles++;
      check_eq("rf_load", 32'(ifc.RF_load), 32'(prev_hs));
      if (prev_hs) check_eq("A_data", 32'(ifc.A), 32'(prev_w));
      check_eq("s_ready",  32'(ifc.s_ready),  32'(phase == 0));
      check_eq("rd_valid", 32'(ifc.rd_valid), 32'(phase == 2));
      check_eq("done",     32'(ifc.done),     32'(phase == 3));
      check_eq("busy",     32'(ifc.busy),     32'd1);
      prev_hs = 0;
      nxt = phase;
      ifc.s_valid = 1'b0; ifc.rd_ready = 1'b0; ifc.abort = 1'b0;
      if (noise) begin
        ifc.start     = 1'($urandom_range(0, 1));
        ifc.burst_len = CW'($urandom);
      end
      case (phase)
        0: begin
          w = fixed_data ? 30'((loaded + 1) * 17) : 30'($urandom);
          ifc.s_data  = w;
          ifc.s_valid = 1'($urandom_range(0, 99) < pv);
          if (ifc.s_valid) begin
            if (loaded + 1 == abort_at) begin
              ifc.abort = 1'b1;
              tick();
              ifc.abort = 1'b0; ifc.s_valid = 1'b0; ifc.start = 1'b0;
              check_eq("abort_rfload", 32'(ifc.RF_load), 32'd0);
              check_eq("abort_busy",   32'(ifc.busy), 32'd0);
              check_eq("abort_sready", 32'(ifc.s_ready), 32'd0);
              return;
            end
            prev_hs = 1; prev_w = w; words.push_back(w); loaded++;
            if (loaded == n) nxt = 1;
          end
        end
        1: nxt = 2;
        2: begin
          a0 = addrq[0];
          check_eq("rd_addr", 32'(ifc.ACOUT_addr), 32'(a0));
          check_eq("rd_data", 32'(rf[a0-1]), 32'(words[n-a0]));
          if (rst_at != 0 && reads == rst_at) begin
            RST = 1'b1;
            #1;
            check_eq("inrst_rdvalid", 32'(ifc.rd_valid), 32'd0);
            check_eq("inrst_busy",    32'(ifc.busy), 32'd0);
            tick();
            RST = 1'b0; ifc.start = 1'b0;
            check_reset_outputs("rst_read");
            return;
          end
          if (hold_k2 && (n - a0) == 2 && hold < 3) begin
            hold++;
            ifc.rd_ready = 1'b0;
          end else if (hold_k2) begin
            ifc.rd_ready = 1'b1;
          end else begin
            ifc.rd_ready = 1'($urandom_range(0, 99) < pr);
          end
          if (ifc.rd_ready) begin
            void'(addrq.pop_front());
            reads++;
            if (addrq.size() == 0) nxt = 3;
          end
        end
        3: nxt = 4;
        default: nxt = 4;
      endcase
      tick();
      phase = nxt;
    end
    ifc.start = 1'b0; ifc.s_valid = 1'b0; ifc.rd_ready = 1'b0;
    check_eq("job_timeout", 32'(cycles >= 2000), 32'd0);
    check_eq("end_busy",   32'(ifc.busy), 32'd0);
    check_eq("end_done",   32'(ifc.done), 32'd0);
    check_eq("end_rfload", 32'(ifc.RF_load), 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    ifc.start = 1'b0; ifc.abort = 1'b0; ifc.burst_len = '0; ifc.repeat_cnt = '0;
    ifc.s_data = '0; ifc.s_valid = 1'b0; ifc.rd_ready = 1'b0;
    for (int i = 0; i < int'(SIZE); i++) rf[i] = '0;
    // Reset must beat start and abort presented alongside it.
    ifc.start = 1'b1; ifc.abort = 1'b1; ifc.burst_len = CW'(3);
    tick();
    tick();
    ifc.start = 1'b0; ifc.abort = 1'b0;
    check_reset_outputs("reset");
    RST = 1'b0;
    tick();
    check_eq("idle_busy", 32'(ifc.busy), 32'd0);

    run_job(4, 0, 100, 100, 0, 0, 1'b1, 1'b0, 1'b0);   // nominal
    run_job(4, 0, 50, 100, 0, 0, 1'b0, 1'b1, 1'b0);    // backpressure, hold at k=2
    run_job(12, 2, 100, 100, 0, 0, 1'b0, 1'b0, 1'b0);  // clamp + repeat
    run_job(0, 0, 100, 100, 0, 0, 1'b0, 1'b0, 1'b0);   // zero length
    run_job(5, 0, 100, 100, 3, 0, 1'b0, 1'b0, 1'b0);   // abort on 3rd load
    run_job(6, 1, 80, 80, 0, 5, 1'b0, 1'b0, 1'b0);     // reset during read
    run_job(2, 0, 100, 100, 0, 0, 1'b0, 1'b0, 1'b0);   // clean job after reset
    run_job(3, 1, 100, 100, 0, 0, 1'b0, 1'b0, 1'b1);   // start while busy
    for (int j = 0; j < 25; j++) begin
      run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
              int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
              0, 0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
